bank_request_router: RTL and testbench

Registered, handshaked successor to the combinational bank decoder. Sits between a single requester and BANKS memory banks. Accepts read/write requests with valid/ready, decodes the address into a bank index and a bank-local address (contiguous or interleaved mapping), and holds each request in an output stage until the target bank accepts it. Returns read data to the requester strictly in issue order, using a bank-index tracking FIFO.

---
 rtl/bank_request_router_if.sv | 41 ++++
 rtl/bank_request_router.sv | 177 +++++++++++++++++
 tb/tb_bank_request_router.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bank_request_router_if.sv
// Request, bank-side and response signals of bank_request_router.
// slave = router view, master = requester/bank environment view.
interface bank_request_router_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BANKS      = 3
);
    localparam int BANK_SIZE  = ((2 ** ADDR_WIDTH) - 1) / BANKS + 1;
    localparam int BANK_WIDTH = $clog2(BANK_SIZE);

    logic                        valid_in;
    logic                        ready_out;
    logic [ADDR_WIDTH-1:0]       address_in;
    logic                        write_in;
    logic [DATA_WIDTH-1:0]       wdata_in;
    logic [BANKS-1:0]            valid_out;
    logic [BANKS-1:0]            bank_ready_in;
    logic [BANK_WIDTH-1:0]       address_out;
    logic                        write_out;
    logic [DATA_WIDTH-1:0]       wdata_out;
    logic [BANKS-1:0]            bank_rvalid_in;
    logic [BANKS*DATA_WIDTH-1:0] bank_rdata_in;
    logic [BANKS-1:0]            bank_rready_out;
    logic                        rvalid_out;
    logic [DATA_WIDTH-1:0]       rdata_out;
    logic                        rready_in;

    modport slave (
        input  valid_in, address_in, write_in, wdata_in, bank_ready_in,
               bank_rvalid_in, bank_rdata_in, rready_in,
        output ready_out, valid_out, address_out, write_out, wdata_out,
               bank_rready_out, rvalid_out, rdata_out
    );

    modport master (
        output valid_in, address_in, write_in, wdata_in, bank_ready_in,
               bank_rvalid_in, bank_rdata_in, rready_in,
        input  ready_out, valid_out, address_out, write_out, wdata_out,
               bank_rready_out, rvalid_out, rdata_out
    );
endinterface

// File: rtl/bank_request_router.sv
// Registered request router to BANKS memory banks with in-order read return.
// Optional BANK_ROUTER_STATS_EN adds a saturating back-pressure stall counter.
module bank_request_router #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BANKS      = 3,
    parameter int MODE       = 0,
    parameter int RSP_DEPTH  = 4
) (
    input  logic clk,
    input  logic rst_n,
`ifdef BANK_ROUTER_STATS_EN
    output logic [15:0] stall_cnt_out,
`endif
    bank_request_router_if.slave bus
);
    localparam int BANK_SIZE  = ((2 ** ADDR_WIDTH) - 1) / BANKS + 1;
    localparam int BANK_WIDTH = $clog2(BANK_SIZE);
    localparam int LOG2_BANK  = $clog2(BANKS);
    localparam int PTR_W      = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W      = $clog2(RSP_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] BANK_SIZE_A = ADDR_WIDTH'(BANK_SIZE);
    localparam logic [ADDR_WIDTH-1:0] BANKS_A     = ADDR_WIDTH'(BANKS);

    logic [ADDR_WIDTH-1:0] dec_bank_full;
    logic [ADDR_WIDTH-1:0] dec_local_full;
    logic [LOG2_BANK-1:0]  dec_bank;
    logic [BANK_WIDTH-1:0] dec_local;
    logic                  unused_dec;

    generate
        if (MODE == 0) begin : g_contig
            assign dec_bank_full  = bus.address_in / BANK_SIZE_A;
            assign dec_local_full = bus.address_in - dec_bank_full * BANK_SIZE_A;
        end else begin : g_inter
            assign dec_bank_full  = bus.address_in % BANKS_A;
            assign dec_local_full = bus.address_in / BANKS_A;
        end
    endgenerate

    assign dec_bank   = dec_bank_full[LOG2_BANK-1:0];
    assign dec_local  = dec_local_full[BANK_WIDTH-1:0];
    assign unused_dec = ^{dec_bank_full[ADDR_WIDTH-1:LOG2_BANK],
                          dec_local_full[ADDR_WIDTH-1:BANK_WIDTH]};

    logic                  occ_q,   occ_d;
    logic [LOG2_BANK-1:0]  bank_q,  bank_d;
    logic [BANK_WIDTH-1:0] local_q, local_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic [LOG2_BANK-1:0]  trk_q [RSP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      rsp_cnt_q;

    logic [BANKS-1:0]      req_onehot;
    logic [BANKS-1:0]      head_onehot;
    logic [LOG2_BANK-1:0]  head;
    logic                  drain, accept, ready, fifo_full, rsp_pend;
    logic                  push, pop, rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        req_onehot = '0;
        for (int i = 0; i < BANKS; i++) begin
            req_onehot[i] = occ_q && (bank_q == LOG2_BANK'(i));
        end
    end

    assign drain     = |(req_onehot & bus.bank_ready_in);
    assign fifo_full = (rsp_cnt_q == CNT_W'(RSP_DEPTH));
    // Writes never wait on read tracking space
    assign ready     = (!occ_q || drain) && (bus.write_in || !fifo_full);
    assign accept    = bus.valid_in && ready;

    always_comb begin
        occ_d   = occ_q;
        bank_d  = bank_q;
        local_d = local_q;
        write_d = write_q;
        wdata_d = wdata_q;
        if (accept) begin
            occ_d   = 1'b1;
            bank_d  = dec_bank;
            local_d = dec_local;
            write_d = bus.write_in;
            wdata_d = bus.wdata_in;
        end else if (drain) begin
            occ_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q   <= 1'b0;
            bank_q  <= '0;
            local_q <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            occ_q   <= occ_d;
            bank_q  <= bank_d;
            local_q <= local_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
        end
    end

    assign rsp_pend = (rsp_cnt_q != '0);
    assign head     = trk_q[rd_ptr_q];

    always_comb begin
        head_onehot = '0;
        rdata       = '0;
        for (int i = 0; i < BANKS; i++) begin
            if (head == LOG2_BANK'(i)) begin
                head_onehot[i] = rsp_pend;
                rdata          = bus.bank_rdata_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign rvalid = |(head_onehot & bus.bank_rvalid_in);
    assign push   = accept && !bus.write_in;
    assign pop    = rvalid && bus.rready_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rsp_cnt_q <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                trk_q[i] <= '0;
            end
        end else begin
            if (push) begin
                trk_q[wr_ptr_q] <= dec_bank;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                rsp_cnt_q <= rsp_cnt_q + CNT_W'(1);
            end else if (pop && !push) begin
                rsp_cnt_q <= rsp_cnt_q - CNT_W'(1);
            end
        end
    end

`ifdef BANK_ROUTER_STATS_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (occ_q && !drain && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt_out = stall_cnt_q;
`endif

    assign bus.ready_out       = ready;
    assign bus.valid_out       = req_onehot;
    assign bus.address_out     = local_q;
    assign bus.write_out       = write_q;
    assign bus.wdata_out       = wdata_q;
    assign bus.rvalid_out      = rvalid;
    assign bus.rdata_out       = rdata;
    assign bus.bank_rready_out = head_onehot & {BANKS{bus.rready_in}};
endmodule

// File: tb/tb_bank_request_router.sv
// Bench for bank_request_router: one MODE 0 and one MODE 1 instance,
// directed vectors, corner sequences and a randomized transaction-level model.
module tb_bank_request_router;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int NB    = 3;
    localparam int DEPTH = 4;
    localparam int BSZ   = ((1 << AW) - 1) / NB + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic        v_in  [2];
    logic [3:0]  a_in  [2];
    logic        w_in  [2];
    logic [7:0]  wd_in [2];
    logic [2:0]  brdy  [2];
    logic [2:0]  brv   [2];
    logic [23:0] brd   [2];
    logic        rrdy  [2];

    logic        rdy_o [2];
    logic [2:0]  vo    [2];
    logic [2:0]  ao    [2];
    logic        wo    [2];
    logic [7:0]  wdo   [2];
    logic [2:0]  brr   [2];
    logic        rv    [2];
    logic [7:0]  rd    [2];
`ifdef BANK_ROUTER_STATS_EN
    logic [15:0] stall [2];
`endif

    for (genvar k = 0; k < 2; k++) begin : g_dut
        bank_request_router_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANKS(NB)) bus ();

        assign bus.valid_in       = v_in[k];
        assign bus.address_in     = a_in[k];
        assign bus.write_in       = w_in[k];
        assign bus.wdata_in       = wd_in[k];
        assign bus.bank_ready_in  = brdy[k];
        assign bus.bank_rvalid_in = brv[k];
        assign bus.bank_rdata_in  = brd[k];
        assign bus.rready_in      = rrdy[k];
        assign rdy_o[k] = bus.ready_out;
        assign vo[k]    = bus.valid_out;
        assign ao[k]    = bus.address_out;
        assign wo[k]    = bus.write_out;
        assign wdo[k]   = bus.wdata_out;
        assign brr[k]   = bus.bank_rready_out;
        assign rv[k]    = bus.rvalid_out;
        assign rd[k]    = bus.rdata_out;

        bank_request_router #(
            .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANKS(NB), .MODE(k), .RSP_DEPTH(DEPTH)
        ) u_dut (
            .clk(clk),
            .rst_n(rst_n),
`ifdef BANK_ROUTER_STATS_EN
            .stall_cnt_out(stall[k]),
`endif
            .bus(bus)
        );
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        for (int k = 0; k < 2; k++) begin
            v_in[k] = 1'b0; a_in[k] = '0; w_in[k] = 1'b0; wd_in[k] = '0;
            brdy[k] = '1; brv[k] = '0; brd[k] = '0; rrdy[k] = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
    endtask

    function automatic void map_addr(input int mode, input int a, output int b, output int l);
        if (mode == 0) begin
            b = a / BSZ;
            l = a - b * BSZ;
        end else begin
            b = a % NB;
            l = a / NB;
        end
    endfunction

    function automatic int resp_val(input int b, input int l);
        return (b * 37 + l * 11 + 90) % 256;
    endfunction

    typedef struct {
        int mode; int addr; bit wr; int wd; int exp_v; int exp_l;
    } vec_t;

    typedef struct {
        int bank; int loc; bit wr; int wd;
    } req_t;

    task automatic run_random(input int m, input int cycles);
        req_t rq[$];
        int   oq[$];
        int   bq[3][$];
        for (int c = 0; c < cycles; c++) begin
            int fb, hb, nreads, vo_e, brr_e, b, l;
            bit occ_e, drain_e, rdy_e, rv_e;
            logic [23:0] d;
            v_in[m]  = 1'($urandom_range(0, 1));
            a_in[m]  = 4'($urandom_range(0, 15));
            w_in[m]  = 1'($urandom_range(0, 1));
            wd_in[m] = 8'($urandom_range(0, 255));
            brdy[m]  = 3'($urandom_range(0, 7));
            rrdy[m]  = ($urandom_range(0, 3) != 0);
            d = '0;
            for (int i = 0; i < NB; i++) begin
                brv[m][i] = (bq[i].size() != 0) && ($urandom_range(0, 2) != 0);
                d[i*8 +: 8] = (bq[i].size() != 0) ? 8'(bq[i][0]) : 8'($urandom_range(0, 255));
            end
            brd[m] = d;

            occ_e   = (rq.size() != 0);
            fb      = occ_e ? rq[0].bank : 0;
            drain_e = occ_e && brdy[m][fb];
            nreads  = oq.size();
            rdy_e   = (!occ_e || drain_e) && (w_in[m] || nreads < DEPTH);
            vo_e    = occ_e ? (1 << fb) : 0;
            hb      = (nreads != 0) ? oq[0] : 0;
            rv_e    = (nreads != 0) && brv[m][hb];
            brr_e   = ((nreads != 0) && rrdy[m]) ? (1 << hb) : 0;
            #1;
            chk("rnd ready_out", rdy_o[m], rdy_e);
            chk("rnd valid_out", vo[m], vo_e);
            chk("rnd bank_rready_out", brr[m], brr_e);
            chk("rnd rvalid_out", rv[m], rv_e);
            if (occ_e) begin
                chk("rnd address_out", ao[m], rq[0].loc);
                chk("rnd write_out", wo[m], rq[0].wr);
                if (rq[0].wr) chk("rnd wdata_out", wdo[m], rq[0].wd);
            end
            if (rv_e) chk("rnd rdata_out", rd[m], bq[hb][0]);

            if (drain_e) begin
                req_t r;
                r = rq.pop_front();
                if (!r.wr) bq[r.bank].push_back(resp_val(r.bank, r.loc));
            end
            if (rv_e && rrdy[m]) begin
                void'(oq.pop_front());
                void'(bq[hb].pop_front());
            end
            if (v_in[m] && rdy_e) begin
                req_t r;
                map_addr(m, int'(a_in[m]), b, l);
                r.bank = b; r.loc = l; r.wr = w_in[m]; r.wd = int'(wd_in[m]);
                rq.push_back(r);
                if (!w_in[m]) oq.push_back(b);
            end
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[12];
        vt[0]  = '{0, 13, 1'b1, 8'hA5, 3'b100, 1};
        vt[1]  = '{0, 15, 1'b1, 8'h3C, 3'b100, 3};
        vt[2]  = '{0,  0, 1'b1, 8'h01, 3'b001, 0};
        vt[3]  = '{0,  5, 1'b1, 8'h02, 3'b001, 5};
        vt[4]  = '{0,  6, 1'b1, 8'h03, 3'b010, 0};
        vt[5]  = '{0, 11, 1'b1, 8'h04, 3'b010, 5};
        vt[6]  = '{0, 12, 1'b1, 8'h05, 3'b100, 0};
        vt[7]  = '{1, 13, 1'b0, 8'h00, 3'b010, 4};
        vt[8]  = '{1, 15, 1'b1, 8'h77, 3'b001, 5};
        vt[9]  = '{1,  2, 1'b1, 8'h88, 3'b100, 0};
        vt[10] = '{1,  7, 1'b1, 8'h99, 3'b010, 2};
        vt[11] = '{1,  0, 1'b1, 8'h11, 3'b001, 0};

        // reset values
        do_reset();
        for (int m = 0; m < 2; m++) begin
            chk("rst valid_out", vo[m], 0);
            chk("rst address_out", ao[m], 0);
            chk("rst write_out", wo[m], 0);
            chk("rst wdata_out", wdo[m], 0);
            chk("rst rvalid_out", rv[m], 0);
            chk("rst bank_rready_out", brr[m], 0);
            chk("rst ready_out", rdy_o[m], 1);
        end

        // address decode vectors
        for (int i = 0; i < 12; i++) begin
            int m;
            m = vt[i].mode;
            v_in[m] = 1'b1; a_in[m] = 4'(vt[i].addr);
            w_in[m] = vt[i].wr; wd_in[m] = 8'(vt[i].wd);
            #1 chk("vec ready_out", rdy_o[m], 1);
            tick();
            v_in[m] = 1'b0;
            #1;
            chk("vec valid_out", vo[m], vt[i].exp_v);
            chk("vec address_out", ao[m], vt[i].exp_l);
            chk("vec write_out", wo[m], vt[i].wr);
            if (vt[i].wr) chk("vec wdata_out", wdo[m], vt[i].wd);
            tick();
        end

        // MODE 1 streaming 0..5, one accept per cycle
        do_reset();
        v_in[1] = 1'b1; w_in[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a_in[1] = 4'(i); wd_in[1] = 8'(i);
            #1 chk("stream ready_out", rdy_o[1], 1);
            tick();
            chk("stream valid_out", vo[1], 1 << (i % NB));
            chk("stream address_out", ao[1], i / NB);
        end
        v_in[1] = 1'b0;
        tick();

        // out-of-order bank responses returned in issue order
        do_reset();
        v_in[0] = 1'b1; w_in[0] = 1'b0; a_in[0] = 4'd13;
        #1 chk("ord ready0", rdy_o[0], 1);
        tick();
        a_in[0] = 4'd1;
        #1 chk("ord ready1", rdy_o[0], 1);
        tick();
        v_in[0] = 1'b0;
        brv[0] = 3'b001; brd[0][7:0] = 8'h11;
        #1;
        chk("ord rvalid held", rv[0], 0);
        chk("ord bank_rready0 low", brr[0][0], 0);
        chk("ord bank_rready head", brr[0], 3'b100);
        tick();
        chk("ord rvalid held2", rv[0], 0);
        tick();
        brv[0] = 3'b101; brd[0][23:16] = 8'h22;
        #1;
        chk("ord rvalid first", rv[0], 1);
        chk("ord rdata first", rd[0], 8'h22);
        tick();
        brv[0] = 3'b001;
        #1;
        chk("ord rvalid second", rv[0], 1);
        chk("ord rdata second", rd[0], 8'h11);
        chk("ord bank_rready second", brr[0], 3'b001);
        tick();
        brv[0] = 3'b000;
        #1 chk("ord rvalid done", rv[0], 0);

        // tracking FIFO full blocks reads only
        do_reset();
        v_in[0] = 1'b1; w_in[0] = 1'b0; a_in[0] = 4'd0;
        for (int i = 0; i < DEPTH; i++) begin
            #1 chk("full fill ready", rdy_o[0], 1);
            tick();
        end
        #1 chk("full read blocked", rdy_o[0], 0);
        w_in[0] = 1'b1; wd_in[0] = 8'hEE;
        #1 chk("full write passes", rdy_o[0], 1);
        tick();
        w_in[0] = 1'b0;
        #1 chk("full read blocked2", rdy_o[0], 0);
        brv[0] = 3'b001; brd[0][7:0] = 8'h40;
        #1 chk("full rvalid", rv[0], 1);
        tick();
        brv[0] = 3'b000;
        #1 chk("full read after pop", rdy_o[0], 1);
        tick();
        v_in[0] = 1'b0;
        #1 chk("full refilled", rdy_o[0], 0);

        // back-pressure hold, then reset mid-stall
        do_reset();
        brdy[0] = 3'b101;
        v_in[0] = 1'b1; w_in[0] = 1'b0; a_in[0] = 4'd0;
        tick();
        w_in[0] = 1'b1; a_in[0] = 4'd6; wd_in[0] = 8'h5C;
        tick();
        a_in[0] = 4'd13; wd_in[0] = 8'hFF;
        for (int j = 0; j < 5; j++) begin
            #1;
            chk("stall valid_out", vo[0], 3'b010);
            chk("stall address_out", ao[0], 0);
            chk("stall write_out", wo[0], 1);
            chk("stall wdata_out", wdo[0], 8'h5C);
            chk("stall ready_out", rdy_o[0], 0);
            tick();
        end
`ifdef BANK_ROUTER_STATS_EN
        chk("stall_cnt_out", stall[0], 5);
`endif
        v_in[0] = 1'b0;
        brv[0] = 3'b001; brd[0][7:0] = 8'h33;
        #1 chk("stall pending rvalid", rv[0], 1);
        rst_n = 1'b0;
        #1;
        chk("rst mid valid_out", vo[0], 0);
        chk("rst mid rvalid_out", rv[0], 0);
        chk("rst mid bank_rready_out", brr[0], 0);
`ifdef BANK_ROUTER_STATS_EN
        chk("rst mid stall_cnt_out", stall[0], 0);
`endif

        // randomized traffic against the transaction model
        do_reset();
        run_random(0, 500);
        do_reset();
        run_random(1, 500);
        do_reset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
